// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_pkg
// Description : Shared constants and types for the SPI register slave.
//               Optional build macro: SPI_MSB_FIRST_EN (see spi_reg_slave).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    localparam int DATA_W = 8;   // command, register and shift width
    localparam int NREGS  = 8;   // readable registers, addresses 1..NREGS
    localparam int CNT_W  = 3;   // bit counter width, wraps once per byte

    // Returned for address 0 or any address above NREGS
    localparam logic [DATA_W-1:0] c_INVALID_DATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/spi_reg_mux.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_mux
// Description : Combinational address-to-register select. Addresses 1..NREGS
//               pick the matching register slice, all others give 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_mux
    import spi_reg_pkg::*;
(
    input  logic [DATA_W-1:0]       addr,
    input  logic [NREGS*DATA_W-1:0] regs,   // reg1 in the lowest slice
    output logic [DATA_W-1:0]       data
);

    // Default to the invalid-address value, override on an exact match
    always_comb begin
        data = c_INVALID_DATA;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == DATA_W'(i + 1)) begin
                data = regs[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule : spi_reg_mux
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave
// Description : SPI slave returning one of eight read-only registers. An
//               8-bit command selects the address, the register is then
//               shifted out on MISO. All four SPI modes via cpol/cpoh.
//               Build macro SPI_MSB_FIRST_EN: shift command and response
//               MSB-first instead of the default LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_slave
    import spi_reg_pkg::*;
(
    input  logic              sck,
    input  logic              reset,    // synchronous, active-low
    input  logic              ss,
    input  logic              cpol,
    input  logic              cpoh,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] reg3,
    input  logic [DATA_W-1:0] reg4,
    input  logic [DATA_W-1:0] reg5,
    input  logic [DATA_W-1:0] reg6,
    input  logic [DATA_W-1:0] reg7,
    input  logic [DATA_W-1:0] reg8,
    output logic              MISO
);

    // Rising edge of this clock is the sample edge in every SPI mode
    logic w_clk;
    assign w_clk = sck ^ (cpol ^ cpoh);

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt,   w_cnt;
    logic [DATA_W-1:0] r_cmd,   w_cmd;
    logic [DATA_W-1:0] r_shift, w_shift;
    logic              r_miso,  w_miso;

    logic [DATA_W-1:0] w_cmd_first;   // command reg after its first bit
    logic [DATA_W-1:0] w_cmd_shift;   // command reg after one more bit
    logic [DATA_W-1:0] w_sel;         // register chosen by the full command
    logic              w_sel_lead;    // first response bit of w_sel
    logic [DATA_W-1:0] w_shift_next;  // response reg after one shift
    logic              w_shift_lead;  // bit exposed after that shift

`ifdef SPI_MSB_FIRST_EN
    assign w_cmd_first  = {{(DATA_W-1){1'b0}}, MOSI};
    assign w_cmd_shift  = {r_cmd[DATA_W-2:0], MOSI};
    assign w_sel_lead   = w_sel[DATA_W-1];
    assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
    assign w_shift_lead = r_shift[DATA_W-2];
`else
    assign w_cmd_first  = {MOSI, {(DATA_W-1){1'b0}}};
    assign w_cmd_shift  = {MOSI, r_cmd[DATA_W-1:1]};
    assign w_sel_lead   = w_sel[0];
    assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
    assign w_shift_lead = r_shift[1];
`endif

    // On the last command edge w_cmd_shift already holds the full command
    spi_reg_mux u_mux (
        .addr (w_cmd_shift),
        .regs ({reg8, reg7, reg6, reg5, reg4, reg3, reg2, reg1}),
        .data (w_sel)
    );

    // Next-state and datapath decode; everything holds unless changed
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_cmd   = r_cmd;
        w_shift = r_shift;
        w_miso  = r_miso;
        case (r_state)
            IDLE: begin
                w_miso = 1'b0;
                if (ss) begin
                    w_cmd   = w_cmd_first;
                    w_cnt   = CNT_W'(1);
                    w_state = CMD;
                end
            end
            CMD: begin
                // ss is deliberately ignored so the master may drop it early
                w_cmd = w_cmd_shift;
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_shift = w_sel;
                    w_miso  = w_sel_lead;
                    w_cnt   = CNT_W'(1);
                    w_state = RESP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (ss) begin
                    // Abort: this edge carries bit0 of a new command
                    w_cmd   = w_cmd_first;
                    w_cnt   = CNT_W'(1);
                    w_miso  = 1'b0;
                    w_state = CMD;
                end else if (r_cnt == '0) begin
                    // Counter wrapped: last response bit has been consumed
                    w_miso  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_shift = w_shift_next;
                    w_miso  = w_shift_lead;
                    w_cnt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
                w_miso  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge w_clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_shift <= '0;
            r_miso  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_cmd   <= w_cmd;
            r_shift <= w_shift;
            r_miso  <= w_miso;
        end
    end

    assign MISO = r_miso;

endmodule : spi_reg_slave
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_slave
// Description : Directed self-checking bench for spi_reg_slave in all four
//               SPI modes, including abort, reset and invalid addresses.
//               Follows SPI_MSB_FIRST_EN for the bit order it drives/expects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

    logic       sck   = 1'b0;
    logic       reset = 1'b0;
    logic       ss    = 1'b0;
    logic       cpol  = 1'b0;
    logic       cpoh  = 1'b0;
    logic       mosi  = 1'b0;
    logic [7:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8;
    logic       miso;
    logic       smp;

    int n_cmp = 0;
    int n_err = 0;

    spi_reg_slave dut (
        .sck   (sck),
        .reset (reset),
        .ss    (ss),
        .cpol  (cpol),
        .cpoh  (cpoh),
        .MOSI  (mosi),
        .reg1  (reg1),
        .reg2  (reg2),
        .reg3  (reg3),
        .reg4  (reg4),
        .reg5  (reg5),
        .reg6  (reg6),
        .reg7  (reg7),
        .reg8  (reg8),
        .MISO  (miso)
    );

    // Free-running serial clock
    always #5 sck = ~sck;

    // Bench copy of the sample edge for the current mode
    assign smp = sck ^ (cpol ^ cpoh);

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next sample edge
    task automatic tick();
        @(posedge smp);
        #1;
    endtask

    // i-th bit on the wire for byte v
    function automatic logic wire_bit(input logic [7:0] v, input int i);
`ifdef SPI_MSB_FIRST_EN
        return v[7-i];
`else
        return v[i];
`endif
    endfunction

    // Eight command bits, ss dropped while the last bit is on MOSI
    task automatic send_cmd(input logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            ss   = (i < 7);
            mosi = wire_bit(c, i);
            tick();
        end
        ss   = 1'b0;
        mosi = 1'b0;
    endtask

    // Called just after the 8th edge; checks 8 response bits then idle 0
    task automatic check_resp(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s bit%0d", tag, i), {7'b0, miso}, {7'b0, wire_bit(exp, i)});
            tick();
        end
        check($sformatf("%s tail", tag), {7'b0, miso}, 8'h00);
    endtask

    // Modes change only while reset is held low
    task automatic set_mode(input logic pol, input logic pha);
        reset = 1'b0;
        ss    = 1'b0;
        tick();
        cpol = pol;
        cpoh = pha;
        tick();
        tick();
        tick();
        check($sformatf("reset miso mode%0d%0d", pol, pha), {7'b0, miso}, 8'h00);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reg1 = 8'h11; reg2 = 8'h42; reg3 = 8'h4C; reg4 = 8'h5A;
        reg5 = 8'h08; reg6 = 8'hAB; reg7 = 8'h7E; reg8 = 8'hC8;

        // Mode 00
        set_mode(1'b0, 1'b0);
        send_cmd(8'h02); check_resp("m00 reg2", 8'h42);
        send_cmd(8'h08); check_resp("m00 reg8", 8'hC8);
        send_cmd(8'h00); check_resp("m00 addr0", 8'h00);
        send_cmd(8'h09); check_resp("m00 addr9", 8'h00);
        send_cmd(8'h81); check_resp("m00 addr81", 8'h00);
        send_cmd(8'h01); check_resp("m00 reg1", 8'h11);
        send_cmd(8'h07); check_resp("m00 reg7", 8'h7E);

        // Register changes after command completion must not leak through
        send_cmd(8'h02);
        reg2 = 8'hFF;
        check_resp("m00 reg2 frozen", 8'h42);
        reg2 = 8'h42;

        // Idle with ss low keeps MISO low
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle miso", {7'b0, miso}, 8'h00);
        end

        // Mode 01: sample on falling sck
        set_mode(1'b0, 1'b1);
        send_cmd(8'h03); check_resp("m01 reg3", 8'h4C);

        // Mode 10: abort reg6 response after one bit with a new command
        set_mode(1'b1, 1'b0);
        send_cmd(8'h06);
        check("m10 reg6 bit0", {7'b0, miso}, 8'h01);
        send_cmd(8'h03); check_resp("m10 reg3 after abort", 8'h4C);

        // Mode 11
        set_mode(1'b1, 1'b1);
        send_cmd(8'h05); check_resp("m11 reg5", 8'h08);

        // Reset mid-command, then a clean transfer
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ss   = 1'b1;
            mosi = wire_bit(8'h08, i);
            tick();
        end
        reset = 1'b0;
        mosi  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset mid cmd miso", {7'b0, miso}, 8'h00);
        end
        reset = 1'b1;
        ss    = 1'b0;
        mosi  = 1'b0;
        tick();
        send_cmd(8'h02); check_resp("post reset reg2", 8'h42);

        // Reset mid-response drops MISO and leaves no partial result
        send_cmd(8'h06);
        check("reg6 before reset", {7'b0, miso}, 8'h01);
        reset = 1'b0;
        tick();
        check("reset mid resp miso", {7'b0, miso}, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after resp reset miso", {7'b0, miso}, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_reg_slave
`default_nettype wire
